// File: rtl/bp_pe_scheduler.sv
// Butterfly sequencer for one shared min-sum PE in a polar BP decoder.
// Walks L sweeps (stage LOG_N-1 down to 0) then R sweeps (0 up to LOG_N-1),
// issuing read addresses and matching write-back addresses two cycles later.
module bp_pe_scheduler #(
  parameter int LOG_N    = 3,
  parameter int MAX_ITER = 4,
  parameter int ITER_W   = 4,
  parameter int SW       = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              et_ok,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              rd_en,
  output logic              rd_dir,
  output logic [SW-1:0]     rd_stage,
  output logic [LOG_N-1:0]  rd_idx_a,
  output logic [LOG_N-1:0]  rd_idx_b,
  output logic              wr_en,
  output logic              wr_dir,
  output logic [SW-1:0]     wr_stage,
  output logic [LOG_N-1:0]  wr_idx_a,
  output logic [LOG_N-1:0]  wr_idx_b
);

  // Per-stage counter runs 0..N/2+1: N/2 issue slots then two bubbles.
  localparam int CW = LOG_N + 1;
  localparam logic [CW-1:0] HALF = CW'(2 ** (LOG_N - 1));
  localparam logic [CW-1:0] LAST = CW'(2 ** (LOG_N - 1) + 1);
  localparam logic [SW-1:0] TOP  = SW'(LOG_N - 1);

  typedef enum logic [2:0] {IDLE, LSWEEP, RSWEEP, CHECK, DONE} state_t;

  state_t            state, state_n;
  logic [SW-1:0]     stage, stage_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ITER_W-1:0] iter_n;
  logic              issue_n;
  logic [LOG_N-1:0]  j_v, bit_v, a_n, b_n;

  // Two-deep write-back pipeline: memory read latency plus PE output register.
  logic              p_en, p_dir;
  logic [SW-1:0]     p_stage;
  logic [LOG_N-1:0]  p_a, p_b;

  // State register and sweep position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stage <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic and next-cycle butterfly address generation.
  always_comb begin
    state_n = state;
    stage_n = stage;
    cnt_n   = cnt;
    iter_n  = iter_cnt;
    issue_n = 1'b0;
    j_v     = '0;
    bit_v   = '0;
    a_n     = '0;
    b_n     = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = LSWEEP;
          stage_n = TOP;
          cnt_n   = '0;
          iter_n  = '0;
        end
      end
      LSWEEP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (stage == '0) state_n = RSWEEP;
          else             stage_n = stage - SW'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RSWEEP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (stage == TOP) state_n = CHECK;
          else              stage_n = stage + SW'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      CHECK: begin
        iter_n = iter_cnt + ITER_W'(1);
        if (et_ok || (iter_n == ITER_W'(MAX_ITER))) begin
          state_n = DONE;
        end else begin
          state_n = LSWEEP;
          stage_n = TOP;
          cnt_n   = '0;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    issue_n = ((state_n == LSWEEP) || (state_n == RSWEEP)) && (cnt_n < HALF);
    j_v     = cnt_n[LOG_N-1:0];
    bit_v   = LOG_N'(1) << stage_n;
    a_n     = (((j_v >> stage_n) << stage_n) << 1) | (j_v & (bit_v - LOG_N'(1)));
    b_n     = a_n | bit_v;
  end

  // Registered outputs; address fields read zero outside issue slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      iter_cnt <= '0;
      rd_en    <= 1'b0;
      rd_dir   <= 1'b0;
      rd_stage <= '0;
      rd_idx_a <= '0;
      rd_idx_b <= '0;
      p_en     <= 1'b0;
      p_dir    <= 1'b0;
      p_stage  <= '0;
      p_a      <= '0;
      p_b      <= '0;
      wr_en    <= 1'b0;
      wr_dir   <= 1'b0;
      wr_stage <= '0;
      wr_idx_a <= '0;
      wr_idx_b <= '0;
    end else begin
      busy     <= (state_n == LSWEEP) || (state_n == RSWEEP) || (state_n == CHECK);
      done     <= (state_n == DONE);
      iter_cnt <= iter_n;
      rd_en    <= issue_n;
      rd_dir   <= issue_n && (state_n == RSWEEP);
      rd_stage <= issue_n ? stage_n : '0;
      rd_idx_a <= issue_n ? a_n : '0;
      rd_idx_b <= issue_n ? b_n : '0;
      p_en     <= rd_en;
      p_dir    <= rd_dir;
      p_stage  <= rd_stage;
      p_a      <= rd_idx_a;
      p_b      <= rd_idx_b;
      wr_en    <= p_en;
      wr_dir   <= p_dir;
      wr_stage <= p_stage;
      wr_idx_a <= p_a;
      wr_idx_b <= p_b;
    end
  end

endmodule
